spi_master_seq: RTL and testbench
=================================

SPI_MASTER_SEQ -- requirements
Module: spi_master_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer; SHALL be a multiple of 4.
REQ-002 Parameter DIV_WIDTH, default 8: width of the clock-divider input.
REQ-003 pclk  input  1  system clock; all logic SHALL be clocked on its rising edge; single clock domain.
REQ-004 areset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  transfer request; sampled high in IDLE only.
REQ-006 tx_data  input  DATA_WIDTH  word to transmit, MSB first.
REQ-007 cpol  input  1  SPI clock idle level.
REQ-008 cpha  input  1  SPI clock phase.
REQ-009 lanes  input  2  lane mode: 0 single, 1 dual, 2 quad, 3 reserved.
REQ-010 clk_div  input  DIV_WIDTH  half-period of sclk, minus one, in pclk cycles.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at end of transfer.
REQ-013 rx_data  output  DATA_WIDTH  received word.
REQ-014 sclk  output  1  SPI serial clock.
REQ-015 cs  output  1  chip select, active low.
REQ-016 mosi0..mosi3  output  1 each  master-out lanes.
REQ-017 miso0..miso3  input  1 each  master-in lanes.

Function
REQ-018 FSM states SHALL be IDLE, SETUP, XFER, HOLD; IDLE->SETUP on start; SETUP->XFER after H = clk_div+1 cycles; XFER->HOLD after the last sclk edge; HOLD->IDLE after H cycles.
REQ-019 On accepting start, the block SHALL latch tx_data, cpol, cpha, lanes and clk_div; later input changes SHALL NOT affect the transfer in progress.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 IDLE outputs: cs=1, sclk=latched cpol, mosi0..3=0, busy=0.
REQ-022 cs SHALL go low in the first SETUP cycle and return high in the cycle done pulses.
REQ-023 In XFER, sclk SHALL toggle every H pclk cycles, for exactly 2*BEATS edges, where BEATS = DATA_WIDTH/L and L = 1, 2 or 4 bits per beat.
REQ-024 lanes=3 SHALL behave as single mode.
REQ-025 Lane mapping per beat, MSB first:
  - single: mosi0 carries the bit; miso0 is sampled.
  - dual: mosi1 carries the higher bit, mosi0 the lower.
  - quad: mosi3 carries the highest bit, mosi0 the lowest.
  - Unused mosi lanes SHALL be driven 0; miso lanes are read with the same mapping.
REQ-026 cpha=0: the first beat SHALL be on mosi from the first SETUP cycle. miso SHALL be sampled on each leading edge. The next beat SHALL be driven on each trailing edge, except the last.
REQ-027 cpha=1: each beat SHALL be driven on the leading edge, and miso sampled on the trailing edge.
REQ-028 Timing, with start sampled at cycle 0:
  - first sclk edge at cycle 1+H;
  - done=1, busy 1->0 and cs=1 at cycle 1+H*(2*BEATS+1).
REQ-029 rx_data SHALL update only in the done cycle and SHALL hold its value otherwise.
REQ-030 start coincident with done SHALL be ignored; the next start is accepted no earlier than the cycle after done.
REQ-031 clk_div=0 SHALL give sclk = pclk/2.

Reset
REQ-032 When areset=0, the block SHALL immediately, without waiting for a pclk edge, enter IDLE with cs=1, sclk=0, mosi0..3=0, busy=0, done=0, rx_data=0 and latched config=0.
REQ-033 Assertion of areset mid-transfer SHALL abort the transfer with no done pulse; the first start after reset release SHALL begin a fresh transfer.

Verification
REQ-034 Single mode: cpol=0, cpha=0, clk_div=0, tx=0xA5, slave loopback returns 0x3C -> mosi0 shows 1,0,1,0,0,1,0,1; done at cycle 18; rx_data=0x3C.
REQ-035 Quad mode: cpol=1, cpha=1, clk_div=1, tx=0x5A, miso3..0 = 0xC then 0x3 -> sclk idles high, 4 edges each 2 cycles apart; done at cycle 11; rx_data=0xC3.
REQ-036 Dual mode, clk_div=2, tx=0xE4 -> mosi1/mosi0 pairs 11, 10, 01, 00; mosi2=mosi3=0; done at cycle 28.
REQ-037 start pulsed at cycles 5 and 17 of a 0xFF transfer, and held high in the done cycle -> no extra transfers; cs low once; single done pulse.
REQ-038 areset asserted at cycle 9 of an 8-bit single transfer -> cs=1 and sclk=0 with no pclk edge; no done pulse; next start completes normally.

Source files
------------

// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI master with single/dual/quad lanes, CPOL/CPHA select and programmable sclk divider.
module spi_master_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [1:0]            lanes,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi0,
  output logic                  mosi1,
  output logic                  mosi2,
  output logic                  mosi3,
  input  logic                  miso0,
  input  logic                  miso1,
  input  logic                  miso2,
  input  logic                  miso3
);
  localparam int W  = DATA_WIDTH;
  localparam int EW = $clog2(2 * W) + 1;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t               state;
  logic [W-1:0]         tx_sh, rx_sh, tx_nx, rx_nx;
  logic [DIV_WIDTH-1:0] div_l, cnt;
  logic [1:0]           mode;
  logic                 pha, tick, lead, quad, dual;
  logic [EW-1:0]        ecnt, last;
  logic [3:0]           mosi, miso;
  function automatic logic [3:0] beat_of(input logic [W-1:0] s, input logic [1:0] m);
    return m == 2'd2 ? s[W-1 -: 4] : m == 2'd1 ? {2'b00, s[W-1 -: 2]} : {3'b000, s[W-1]};
  endfunction
  assign quad  = mode == 2'd2;
  assign dual  = mode == 2'd1;
  assign tick  = cnt == div_l;
  assign lead  = !ecnt[0];
  assign last  = quad ? EW'(W / 2 - 1) : dual ? EW'(W - 1) : EW'(2 * W - 1);
  assign miso  = {miso3, miso2, miso1, miso0};
  assign tx_nx = quad ? tx_sh << 4 : dual ? tx_sh << 2 : tx_sh << 1;
  assign rx_nx = quad ? (rx_sh << 4) | W'(miso) : dual ? (rx_sh << 2) | W'(miso[1:0]) : (rx_sh << 1) | W'(miso[0]);
  assign busy  = state != IDLE;
  assign {mosi3, mosi2, mosi1, mosi0} = mosi;
  always_ff @(posedge pclk or negedge areset)
    if (!areset) begin
      state   <= IDLE;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= '0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      div_l   <= '0;
      cnt     <= '0;
      mode    <= '0;
      pha     <= 1'b0;
      ecnt    <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == IDLE || tick) ? '0 : cnt + DIV_WIDTH'(1);
      case (state)
        IDLE: if (start && !done) begin
          state <= SETUP;
          cs    <= 1'b0;
          sclk  <= cpol;
          tx_sh <= tx_data;
          rx_sh <= '0;
          div_l <= clk_div;
          mode  <= lanes;
          pha   <= cpha;
          ecnt  <= '0;
          mosi  <= cpha ? 4'h0 : beat_of(tx_data, lanes);
        end
        SETUP, XFER: if (tick) begin
          sclk  <= ~sclk;
          ecnt  <= ecnt + EW'(1);
          state <= ecnt == last ? HOLD : XFER;
          if (lead != pha) rx_sh <= rx_nx;
          // cpha=0 shifts on trailing edges (not the final one); cpha=1 shifts on leading edges
          if ((!lead && !pha && ecnt != last) || (lead && pha)) begin
            mosi  <= beat_of(pha ? tx_sh : tx_nx, mode);
            tx_sh <= tx_nx;
          end
        end
        HOLD: if (tick) begin
          state   <= IDLE;
          done    <= 1'b1;
          cs      <= 1'b1;
          mosi    <= '0;
          rx_data <= rx_sh;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: directed checks of spi_master_seq timing, lane mapping, start filtering and async reset.
module tb_spi_master_seq;
  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [1:0] lanes = '0;
  logic [7:0] clk_div = '0;
  logic       busy, done, sclk, cs, mosi0, mosi1, mosi2, mosi3;
  logic [7:0] rx_data;
  logic       miso0 = 1'b0, miso1 = 1'b0, miso2 = 1'b0, miso3 = 1'b0;
  int errs = 0, checks = 0;
  int dcyc, edges, gapbad, lanebad, csfalls, rxchg;
  logic [7:0] mw;
  logic s1;

  spi_master_seq #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .pclk(pclk), .areset(areset), .start(start), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .lanes(lanes), .clk_div(clk_div), .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .cs(cs), .mosi0(mosi0), .mosi1(mosi1), .mosi2(mosi2), .mosi3(mosi3),
    .miso0(miso0), .miso1(miso1), .miso2(miso2), .miso3(miso3)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // slave model: beat k of sw on the used lanes, unused lanes driven high
  task automatic set_miso(input logic [7:0] sw, input int k, input int l);
    logic [7:0] s;
    logic [3:0] b;
    s = (k < 8 / l) ? sw << (k * l) : 8'h00;
    b = (s[7:4] >> (4 - l)) | (4'hF << l);
    {miso3, miso2, miso1, miso0} = b;
  endtask

  task automatic run(input logic [7:0] tx, input logic p, input logic ph, input logic [1:0] ln,
                     input logic [7:0] dv, input logic [7:0] sw, input int poke, input int abort_at);
    int c, idx, lst, l;
    logic ps, pc;
    logic [7:0] rx0;
    l = ln == 2 ? 4 : ln == 1 ? 2 : 1;
    mw = 0; edges = 0; gapbad = 0; lanebad = 0; csfalls = 0; rxchg = 0; dcyc = -1; idx = 0; lst = -1;
    tx_data = tx; cpol = p; cpha = ph; lanes = ln; clk_div = dv;
    set_miso(sw, 0, l);
    rx0 = rx_data;
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_data = ~tx; cpol = ~p; cpha = ~ph; lanes = ln ^ 2'b01; clk_div = dv + 8'd3;
    c = 1; ps = sclk; pc = 1'b1; s1 = sclk;
    while (c < 200) begin
      if (pc && !cs) csfalls++;
      pc = cs;
      if (!done && rx_data !== rx0) rxchg++;
      if (sclk !== ps) begin
        if (lst >= 0 && c - lst != int'(dv) + 1) gapbad++;
        if (edges == 0 && c != int'(dv) + 2) gapbad++;
        lst = c;
        if (((edges % 2) == 0) == (ph == 1'b0)) begin
          mw = (mw << l) | (l == 4 ? {mosi3, mosi2, mosi1, mosi0} : l == 2 ? {mosi1, mosi0} : mosi0);
          if ((l < 4 && (mosi3 | mosi2)) || (l < 2 && mosi1)) lanebad++;
          idx++;
          set_miso(sw, idx, l);
        end
        edges++;
        ps = sclk;
      end
      if (done) begin
        dcyc = c;
        break;
      end
      if (c == abort_at) break;
      start = (poke != 0) && (c == 5 || c == 17);
      tick();
      c++;
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_mosi", {mosi3, mosi2, mosi1, mosi0}, 0);
    areset = 1'b1;
    tick();

    run(8'hA5, 1'b0, 1'b0, 2'd0, 8'd0, 8'h3C, 0, -1);
    chk("single_done_cyc", dcyc, 18);
    chk("single_rx", rx_data, 8'h3C);
    chk("single_mosi", mw, 8'hA5);
    chk("single_edges", edges, 16);
    chk("single_gap", gapbad, 0);
    chk("single_lanes", lanebad, 0);
    chk("single_csfalls", csfalls, 1);
    chk("single_rxhold", rxchg, 0);
    chk("single_setup_sclk", s1, 0);
    chk("single_done_cs", cs, 1);
    chk("single_done_busy", busy, 0);
    chk("single_done_mosi", {mosi3, mosi2, mosi1, mosi0}, 0);
    tick();

    run(8'h5A, 1'b1, 1'b1, 2'd2, 8'd1, 8'hC3, 0, -1);
    chk("quad_done_cyc", dcyc, 11);
    chk("quad_rx", rx_data, 8'hC3);
    chk("quad_mosi", mw, 8'h5A);
    chk("quad_edges", edges, 4);
    chk("quad_gap", gapbad, 0);
    chk("quad_setup_sclk", s1, 1);
    chk("quad_rxhold", rxchg, 0);
    tick();
    chk("quad_idle_sclk", sclk, 1);

    run(8'hE4, 1'b0, 1'b1, 2'd1, 8'd2, 8'h1B, 0, -1);
    chk("dual_done_cyc", dcyc, 28);
    chk("dual_rx", rx_data, 8'h1B);
    chk("dual_mosi", mw, 8'hE4);
    chk("dual_edges", edges, 8);
    chk("dual_gap", gapbad, 0);
    chk("dual_lanes", lanebad, 0);
    tick();

    run(8'hFF, 1'b0, 1'b0, 2'd0, 8'd0, 8'h81, 1, -1);
    chk("poke_done_cyc", dcyc, 18);
    chk("poke_rx", rx_data, 8'h81);
    chk("poke_mosi", mw, 8'hFF);
    chk("poke_csfalls", csfalls, 1);
    chk("poke_start_at_done", start, 1);
    tick();
    start = 1'b0;
    chk("poke_after_busy", busy, 0);
    chk("poke_after_done", done, 0);
    chk("poke_after_cs", cs, 1);
    repeat (3) tick();
    chk("poke_idle_busy", busy, 0);

    run(8'hA5, 1'b1, 1'b0, 2'd0, 8'd0, 8'h3C, 0, 9);
    chk("abort_no_done", dcyc, -1);
    chk("abort_pre_busy", busy, 1);
    areset = 1'b0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx", rx_data, 0);
    chk("abort_mosi", {mosi3, mosi2, mosi1, mosi0}, 0);
    tick();
    areset = 1'b1;
    tick();
    chk("abort_idle_done", done, 0);

    run(8'h96, 1'b0, 1'b0, 2'd3, 8'd0, 8'h69, 0, -1);
    chk("resv_done_cyc", dcyc, 18);
    chk("resv_rx", rx_data, 8'h69);
    chk("resv_mosi", mw, 8'h96);
    chk("resv_edges", edges, 16);
    chk("resv_lanes", lanebad, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
